// File: rtl/ibert_pkg.sv
// ibert_pkg: shared types and constants for the IBERT error-injection path.
//   mode_e   - programmed injection mode (off / single / periodic / random)
//   state_e  - scheduler FSM state
//   IBERT_W  - stream word width
//   LFSR_*   - seed and feedback taps of the 16-bit random source
//   lfsr_next() - one Fibonacci shift-left step of x^16+x^14+x^13+x^11+1
package ibert_pkg;

    localparam int          IBERT_W       = 13;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    // Taps x^16, x^14, x^13, x^11 -> register bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_SINGLE   = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_RANDOM   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ibert_lfsr16.sv
// ibert_lfsr16: free-running-on-demand 16-bit Fibonacci LFSR.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, loads SEED
//   adv   - advance one step this cycle
//   q     - current LFSR value
module ibert_lfsr16
    import ibert_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= SEED;
        else if (adv) q <= lfsr_next(q);
    end

endmodule

// File: rtl/err_inject_ctrl.sv
// err_inject_ctrl: registered stream stage that flips one bit of selected
// words on the IBERT pattern stream and counts the injections.
//   clk, rst_n            - clock, asynchronous active-low reset
//   cfg_mode/period/thresh/bit_sel - injection setup, latched on start
//   start, stop           - control pulses (stop wins)
//   in_valid/in_ready/in_data     - upstream handshake
//   out_valid/out_ready/out_data/out_err - downstream handshake, error flag
//   inj_count             - saturating count of injected words since start
//   busy                  - scheduler is ARMED or RUN
// Build option: ERR_RAND_POS_EN takes the flip position from lfsr[3:0] mod 13
// (sampled before the LFSR advances) instead of cfg_bit_sel.
module err_inject_ctrl
    import ibert_pkg::*;
#(
    parameter int          W         = IBERT_W,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [15:0]      cfg_thresh,
    input  logic [3:0]       cfg_bit_sel,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] inj_count,
    output logic             busy
);

    state_e           state, state_n;
    mode_e            mode_q;
    logic [CNT_W-1:0] period_q, period_eff, wcnt, wcnt_inc;
    logic [15:0]      thresh_q;
    logic [15:0]      lfsr_q;
    logic             accept, start_go, run_acc, hit, inject;
    logic [3:0]       pos;
    logic [W-1:0]     mask;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign start_go   = start && !stop;
    assign busy       = (state == ARMED) || (state == RUN);
    // A word accepted together with a control pulse is never injected.
    assign run_acc    = accept && (state == RUN) && !start && !stop;
    assign period_eff = (period_q == '0) ? CNT_W'(1) : period_q;
    assign wcnt_inc   = wcnt + CNT_W'(1);
    assign hit        = (wcnt_inc == period_eff);

    // The LFSR runs on every accepted word regardless of state or mode.
    ibert_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (accept),
        .q     (lfsr_q)
    );

    always_comb begin
        inject = 1'b0;
        if (run_acc) begin
            case (mode_q)
                MODE_SINGLE, MODE_PERIODIC: inject = hit;
                MODE_RANDOM:                inject = (lfsr_q < thresh_q);
                default:                    inject = 1'b0;
            endcase
        end
    end

`ifdef ERR_RAND_POS_EN
    assign pos = lfsr_q[3:0] % 4'd13;
`else
    logic [3:0] sel_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        sel_q <= '0;
        else if (start_go) sel_q <= cfg_bit_sel;
    end
    assign pos = (sel_q >= 4'(W)) ? 4'd0 : sel_q;
`endif

    assign mask = inject ? (W'(1) << pos) : '0;

    always_comb begin
        state_n = state;
        if (stop)          state_n = IDLE;
        else if (start)    state_n = ARMED;
        else begin
            case (state)
                ARMED:   if (accept) state_n = RUN;
                RUN:     if (run_acc && mode_q == MODE_SINGLE && hit) state_n = DONE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_OFF;
            period_q  <= '0;
            thresh_q  <= '0;
            wcnt      <= '0;
            inj_count <= '0;
        end else if (start_go) begin
            mode_q    <= mode_e'(cfg_mode);
            period_q  <= cfg_period;
            thresh_q  <= cfg_thresh;
            wcnt      <= '0;
            inj_count <= '0;
        end else begin
            if (run_acc && (mode_q == MODE_SINGLE || mode_q == MODE_PERIODIC))
                wcnt <= hit ? '0 : wcnt_inc;
            if (inject && inj_count != '1)
                inj_count <= inj_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ mask;
            out_err   <= inject;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
